vga_vram_sched: RTL and testbench
=================================

// Module: vga_vram_sched
// PURPOSE
//  Pixel-clock VRAM scheduler feeding the 8-bit video shift-out stage.
//  Shares one 8-bit VRAM between video fetch and buffered CPU writes. Each
//  8-clock byte slot splits into two 4-clock half-slots; fetch owns half 0.
//  Drives nLoad/parOut so the shift stage reloads once per fetched byte.
// PARAMETERS
//  ADDR_W          15  VRAM address width (bytes)
//  BYTES_PER_LINE  64  video fetches per display line
//  VID_BASE        0   video address loaded on frameStart
//  DEPTH           4   CPU write FIFO entries (power of 2, >=2)
// PORTS
//  clk         in   1       pixel clock; all logic on posedge
//  nReset      in   1       asynchronous, active-low reset
//  frameStart  in   1       1-clk pulse: reload video address
//  lineStart   in   1       1-clk pulse: fetch one line from next slot
//  wrReq       in   1       CPU write push request
//  wrAddr      in   ADDR_W  CPU write address
//  wrData      in   8       CPU write data
//  wrFull      out  1       FIFO holds DEPTH entries
//  wrOvf       out  1       sticky: push attempted while full
//  vramAddr    out  ADDR_W  VRAM address
//  vramDout    out  8       VRAM write data
//  vramDoe     out  1       drive vramDout onto VRAM bus
//  vramDin     in   8       VRAM read data
//  nVramOE     out  1       VRAM output enable, active low
//  nVramWE     out  1       VRAM write enable, active low
//  nLoad       out  1       shift-stage load strobe, active low
//  parOut      out  8       byte presented to shift stage
// BEHAVIOUR
//  - Reset: ph=0, vidAddr=VID_BASE, FIFO empty, fetchCnt=0, linePend=0;
//    vramAddr=0, vramDout=0, vramDoe=0, nVramOE=1, nVramWE=1, nLoad=1,
//    parOut=0, wrFull=0, wrOvf=0. Reset mid-access aborts at once.
//  - ph: 3-bit free-running phase counter; frameStart/lineStart do not reset it.
//  - All outputs registered; "during phase n" = clock where ph==n.
//  - lineStart sets linePend. At next ph0: fetchCnt<=BYTES_PER_LINE,
//    linePend<=0. lineStart during a line restarts the count (no error).
//  - Fetch slot (fetchCnt!=0 at ph0): ph0-3 vramAddr=vidAddr, nVramOE=0;
//    parOut<=vramDin at edge ending ph3; nVramOE=1 from ph4;
//    vidAddr+=1 (wraps mod 2^ADDR_W), fetchCnt-=1. nLoad=0 during ph7.
//  - Non-fetch slot: parOut holds last byte; nLoad stays 1.
//  - Write half-slot base b in {0,4}; b=0 only if not a fetch slot.
//    Starts if FIFO non-empty at edge entering b:
//    b: vramAddr/vramDout=head, vramDoe=1, nVramWE=1, pop;
//    b+1: nVramWE=0; b+2: nVramWE=1, vramDoe=1; b+3: vramDoe=0.
//  - Throughput: 1 write/8 clk in fetch slots, 1 write/4 clk otherwise.
//  - nVramOE and vramDoe never low/high together; fetch always wins half 0.
//  - FIFO: push if wrReq && !wrFull. Pop at write start. Push while full
//    is dropped and sets wrOvf, even if a pop occurs that same clock.
//    Same-clock push+pop when not full: count unchanged, order preserved.
//  - frameStart: vidAddr<=VID_BASE next clk; coincident with a fetch
//    increment, reload wins. Does not touch FIFO, fetchCnt or ph.
// TESTING
//  1 reset: release nReset, no stimulus 16 clk -> all outputs at reset
//    values, nVramOE=nVramWE=nLoad=1 throughout.
//  2 line fetch: frameStart, lineStart, vramDin=addr[7:0]^8'hA5 -> 64
//    slots, vramAddr 0..63 in ph0-3, nLoad=0 at each ph7, parOut=0xA5,
//    0xA4,.. ; then no OE/nLoad activity.
//  3 writes in line: push (0x100,0x11),(0x101,0x22),(0x102,0x33) during
//    fetch -> nVramWE=0 only at ph5 of 3 consecutive slots, fetch unaffected.
//  4 blanking burst: push 5 writes back-to-back, no line -> wrFull=1
//    after 4, 5th dropped, wrOvf=1; writes 4 clk apart, nWE low at ph1/ph5.
//  5 second line: lineStart again w/o frameStart -> addresses 64..127;
//    frameStart + lineStart -> addresses restart at VID_BASE.
//  6 reset mid-write: nReset=0 at ph5 of a write -> nVramWE=1, vramDoe=0
//    immediately, FIFO empty after release, no further writes issued.

Source files
------------

// File: rtl/vga_vram_sched_if.sv
// Bus bundle between the VRAM scheduler and its CPU-write, VRAM and shift-stage neighbours.
// The DUT side uses the slave modport; the master modport is the environment's view.
interface vga_vram_sched_if #(
    parameter int ADDR_W = 15
);
    logic              frameStart;
    logic              lineStart;
    // wrReq/wrFull handshake: a push is taken on every clock where wrReq=1 and
    // wrFull=0; wrReq while wrFull=1 is dropped and latches wrOvf.
    logic              wrReq;
    logic [ADDR_W-1:0] wrAddr;
    logic [7:0]        wrData;
    logic              wrFull;
    logic              wrOvf;
    logic [ADDR_W-1:0] vramAddr;
    logic [7:0]        vramDout;
    logic              vramDoe;
    logic [7:0]        vramDin;
    logic              nVramOE;
    logic              nVramWE;
    logic              nLoad;
    logic [7:0]        parOut;
    logic [1:0]        dbg_state;

    modport slave (
        input  frameStart, lineStart, wrReq, wrAddr, wrData, vramDin,
        output wrFull, wrOvf, vramAddr, vramDout, vramDoe, nVramOE, nVramWE,
               nLoad, parOut, dbg_state
    );

    modport master (
        output frameStart, lineStart, wrReq, wrAddr, wrData, vramDin,
        input  wrFull, wrOvf, vramAddr, vramDout, vramDoe, nVramOE, nVramWE,
               nLoad, parOut, dbg_state
    );
endinterface

// File: rtl/vga_vram_sched.sv
// VRAM time-slot scheduler: video fetch owns half 0 of each 8-clock byte slot,
// buffered CPU writes take the remaining 4-clock halves.
module vga_vram_sched #(
    parameter int                ADDR_W         = 15,
    parameter int                BYTES_PER_LINE = 64,
    parameter logic [ADDR_W-1:0] VID_BASE       = '0,
    parameter int                DEPTH          = 4
) (
    input logic             clk,
    input logic             nReset,
    vga_vram_sched_if.slave bus
);
    localparam int CNT_W = $clog2(BYTES_PER_LINE + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_STROBE, W_HOLD} wr_state_t;

    logic [2:0]        ph;
    logic [ADDR_W-1:0] vid_addr;
    logic [CNT_W-1:0]  fetch_cnt;
    logic              line_pend;
    logic              fetch_slot;
    wr_state_t         wr_state;

    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [7:0]        fifo_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;
    logic              push;
    logic              pop;
    logic              half_start;

    assign push = bus.wrReq && !bus.wrFull;
    // Next clock opens a write half: half 1 always, half 0 only when no fetch claims the slot.
    assign half_start = (ph == 3'd3) || ((ph == 3'd7) && (fetch_cnt == '0));
    assign pop        = half_start && (count != '0) && (wr_state == W_IDLE);
    assign bus.dbg_state = wr_state;

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + (PTR_W+1)'(1);
        else if (pop && !push) count_next = count - (PTR_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.wrAddr;
            fifo_data[wr_ptr] <= bus.wrData;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            ph           <= '0;
            vid_addr     <= VID_BASE;
            fetch_cnt    <= '0;
            line_pend    <= 1'b0;
            fetch_slot   <= 1'b0;
            wr_state     <= W_IDLE;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            bus.wrFull   <= 1'b0;
            bus.wrOvf    <= 1'b0;
            bus.vramAddr <= '0;
            bus.vramDout <= '0;
            bus.vramDoe  <= 1'b0;
            bus.nVramOE  <= 1'b1;
            bus.nVramWE  <= 1'b1;
            bus.nLoad    <= 1'b1;
            bus.parOut   <= '0;
        end else begin
            ph <= ph + 3'd1;

            if (bus.lineStart)  line_pend <= 1'b1;
            else if (ph == 3'd0) line_pend <= 1'b0;

            if ((ph == 3'd0) && line_pend)     fetch_cnt <= CNT_W'(BYTES_PER_LINE);
            else if ((ph == 3'd3) && fetch_slot) fetch_cnt <= fetch_cnt - CNT_W'(1);

            // A frame reload overrides the post-fetch increment landing on the same edge.
            if (bus.frameStart)                vid_addr <= VID_BASE;
            else if ((ph == 3'd3) && fetch_slot) vid_addr <= vid_addr + ADDR_W'(1);

            if (ph == 3'd7) fetch_slot <= (fetch_cnt != '0);
            if ((ph == 3'd7) && (fetch_cnt != '0)) begin
                bus.vramAddr <= vid_addr;
                bus.nVramOE  <= 1'b0;
            end
            if ((ph == 3'd3) && fetch_slot) begin
                bus.nVramOE <= 1'b1;
                bus.parOut  <= bus.vramDin;
            end
            bus.nLoad <= !((ph == 3'd6) && fetch_slot);

            count      <= count_next;
            bus.wrFull <= (count_next == (PTR_W+1)'(DEPTH));
            if (bus.wrReq && bus.wrFull) bus.wrOvf <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            case (wr_state)
                W_IDLE: begin
                    if (pop) begin
                        bus.vramAddr <= fifo_addr[rd_ptr];
                        bus.vramDout <= fifo_data[rd_ptr];
                        bus.vramDoe  <= 1'b1;
                        bus.nVramWE  <= 1'b1;
                        wr_state     <= W_SETUP;
                    end
                end
                W_SETUP: begin
                    bus.nVramWE <= 1'b0;
                    wr_state    <= W_STROBE;
                end
                W_STROBE: begin
                    bus.nVramWE <= 1'b1;
                    wr_state    <= W_HOLD;
                end
                W_HOLD: begin
                    bus.vramDoe <= 1'b0;
                    wr_state    <= W_IDLE;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_vram_sched.sv
// Bench for vga_vram_sched: slot-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_vga_vram_sched;
    localparam int                AW       = 15;
    localparam int                BPL      = 64;
    localparam int                DEPTH    = 4;
    localparam logic [AW-1:0]     VID_BASE = '0;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    logic chk_en = 1'b0;
    int   tests = 0;
    int   fails = 0;

    vga_vram_sched_if #(.ADDR_W(AW)) bus ();

    vga_vram_sched #(
        .ADDR_W(AW), .BYTES_PER_LINE(BPL), .VID_BASE(VID_BASE), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .nReset(nReset),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // VRAM model: every byte reads back as its low address bits xor 0xA5.
    assign bus.vramDin = bus.vramAddr[7:0] ^ 8'hA5;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Model state describes the current clock; it advances at each posedge.
    int              m_cyc, m_ph, m_cnt, wr_t0;
    bit              m_pend, m_fetch, m_ovf;
    logic [AW-1:0]   m_vid, m_slot_addr;
    logic [7:0]      m_par;
    logic [AW+7:0]   m_wr;
    logic [AW+7:0]   exp_q[$];

    always @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            m_cyc = 0; m_ph = 0; m_cnt = 0; wr_t0 = -100;
            m_pend = 0; m_fetch = 0; m_ovf = 0;
            m_vid = VID_BASE; m_slot_addr = '0; m_par = '0; m_wr = '0;
            exp_q.delete();
        end else begin
            int nph;
            bit full_now, nfetch;
            nph = (m_ph + 1) % 8;
            full_now = (exp_q.size() == DEPTH);
            if (m_fetch && m_ph == 3) begin
                m_par = m_slot_addr[7:0] ^ 8'hA5;
                m_vid = m_vid + 1'b1;
                m_cnt = m_cnt - 1;
            end
            if (bus.frameStart) m_vid = VID_BASE;
            if (m_ph == 0 && m_pend) begin
                m_cnt = BPL;
                m_pend = 0;
            end
            if (bus.lineStart) m_pend = 1;
            nfetch = m_fetch;
            if (nph == 0) begin
                nfetch = (m_cnt != 0);
                if (nfetch) m_slot_addr = m_vid;
            end
            if ((nph == 4 || (nph == 0 && !nfetch)) && exp_q.size() > 0) begin
                m_wr = exp_q.pop_front();
                wr_t0 = m_cyc + 1;
            end
            if (bus.wrReq) begin
                if (full_now) m_ovf = 1;
                else exp_q.push_back({bus.wrAddr, bus.wrData});
            end
            m_fetch = nfetch;
            m_ph = nph;
            m_cyc++;
        end
    end

    // ---------------- per-cycle compare + activity monitor ----------------
    int we_ph_q[$];
    int we_cyc_q[$];
    int oe_low_cnt = 0;
    int ld_low_cnt = 0;

    always @(negedge clk) begin
        int dt;
        bit in_wr, rd_half;
        if (chk_en) begin
            dt = m_cyc - wr_t0;
            in_wr = (dt >= 0) && (dt <= 2);
            rd_half = m_fetch && (m_ph < 4);
            chk("nVramOE", 32'(bus.nVramOE), 32'(!rd_half));
            chk("nLoad", 32'(bus.nLoad), 32'(!(m_fetch && m_ph == 7)));
            chk("vramDoe", 32'(bus.vramDoe), 32'(in_wr));
            chk("nVramWE", 32'(bus.nVramWE), 32'(dt != 1));
            chk("parOut", 32'(bus.parOut), 32'(m_par));
            chk("wrFull", 32'(bus.wrFull), 32'(exp_q.size() == DEPTH));
            chk("wrOvf", 32'(bus.wrOvf), 32'(m_ovf));
            chk("oe_doe_excl", 32'(!bus.nVramOE && bus.vramDoe), 32'(0));
            if (rd_half) chk("vramAddr_fetch", 32'(bus.vramAddr), 32'(m_slot_addr));
            if (in_wr) begin
                chk("vramAddr_wr", 32'(bus.vramAddr), 32'(m_wr[AW+7:8]));
                chk("vramDout_wr", 32'(bus.vramDout), 32'(m_wr[7:0]));
            end
            if (!bus.nVramWE) begin
                we_ph_q.push_back(m_ph);
                we_cyc_q.push_back(m_cyc);
            end
            if (!bus.nVramOE) oe_low_cnt++;
            if (!bus.nLoad) ld_low_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ph(input int p);
        for (int i = 0; i < 8 && m_ph != p; i++) tick();
    endtask

    task automatic pulse(input bit fs, input bit ls);
        bus.frameStart = fs;
        bus.lineStart = ls;
        tick();
        bus.frameStart = 1'b0;
        bus.lineStart = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [7:0] d);
        bus.wrReq = 1'b1;
        bus.wrAddr = a;
        bus.wrData = d;
        tick();
        bus.wrReq = 1'b0;
    endtask

    task automatic wait_oe(input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.nVramOE == 1'b0) begin
                found = 1;
                break;
            end
            tick();
        end
        chk(name, 32'(found), 32'(1));
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int exp_ph4 [4];
        bit found;
        exp_ph4[0] = 1; exp_ph4[1] = 5; exp_ph4[2] = 1; exp_ph4[3] = 5;
        bus.frameStart = 1'b0;
        bus.lineStart = 1'b0;
        bus.wrReq = 1'b0;
        bus.wrAddr = '0;
        bus.wrData = '0;

        // 1: reset, then idle
        repeat (3) @(posedge clk);
        #1 nReset = 1'b1;
        chk_en = 1'b1;
        repeat (16) tick();
        chk("t1_vramAddr", 32'(bus.vramAddr), 32'h0);
        chk("t1_parOut", 32'(bus.parOut), 32'h0);
        chk("t1_vramDoe", 32'(bus.vramDoe), 32'h0);
        chk("t1_wrFull", 32'(bus.wrFull), 32'h0);
        chk("t1_wrOvf", 32'(bus.wrOvf), 32'h0);
        chk("t1_activity", 32'(oe_low_cnt + ld_low_cnt + we_ph_q.size()), 32'h0);

        // 2: frame + line fetch
        ld_low_cnt = 0;
        wait_ph(1);
        pulse(1'b1, 1'b1);
        wait_oe("t2_first_oe");
        chk("t2_first_addr", 32'(bus.vramAddr), 32'h0);
        repeat (4) tick();
        chk("t2_par0", 32'(bus.parOut), 32'hA5);
        repeat (8) tick();
        chk("t2_par1", 32'(bus.parOut), 32'hA4);

        // 3: writes during the line land in half 1 of consecutive slots
        we_ph_q.delete();
        we_cyc_q.delete();
        wait_ph(2);
        push(15'h100, 8'h11);
        push(15'h101, 8'h22);
        push(15'h102, 8'h33);
        repeat (24) tick();
        chk("t3_we_count", 32'(we_ph_q.size()), 32'd3);
        if (we_ph_q.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("t3_we_ph", 32'(we_ph_q[i]), 32'd5);
            for (int i = 1; i < 3; i++) chk("t3_we_gap", 32'(we_cyc_q[i] - we_cyc_q[i-1]), 32'd8);
        end
        repeat (520) tick();
        chk("t2_nload_count", 32'(ld_low_cnt), 32'd64);
        chk("t2_last_par", 32'(bus.parOut), 32'h9A);
        oe_low_cnt = 0;
        ld_low_cnt = 0;
        repeat (32) tick();
        chk("t2_idle_oe", 32'(oe_low_cnt), 32'd0);
        chk("t2_idle_nload", 32'(ld_low_cnt), 32'd0);

        // 4: blanking burst, fifth push overflows
        we_ph_q.delete();
        we_cyc_q.delete();
        wait_ph(3);
        for (int i = 0; i < 5; i++) begin
            bus.wrReq = 1'b1;
            bus.wrAddr = AW'(15'h200 + i);
            bus.wrData = 8'(8'hC0 + i);
            if (i == 4) begin
                #2;
                chk("t4_full_after_4", 32'(bus.wrFull), 32'd1);
                chk("t4_no_ovf_yet", 32'(bus.wrOvf), 32'd0);
            end
            tick();
        end
        bus.wrReq = 1'b0;
        chk("t4_ovf", 32'(bus.wrOvf), 32'd1);
        chk("t4_full_drop", 32'(bus.wrFull), 32'd0);
        repeat (20) tick();
        chk("t4_we_count", 32'(we_ph_q.size()), 32'd4);
        if (we_ph_q.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t4_we_ph", 32'(we_ph_q[i]), 32'(exp_ph4[i]));
            for (int i = 1; i < 4; i++) chk("t4_we_gap", 32'(we_cyc_q[i] - we_cyc_q[i-1]), 32'd4);
        end

        // 5: second line continues, frame restart returns to base
        wait_ph(1);
        pulse(1'b0, 1'b1);
        wait_oe("t5_oe_line2");
        chk("t5_line2_addr", 32'(bus.vramAddr), 32'd64);
        repeat (520) tick();
        chk("t5_line2_last_par", 32'(bus.parOut), 32'hDA);
        chk("t5_ovf_sticky", 32'(bus.wrOvf), 32'd1);
        wait_ph(1);
        pulse(1'b1, 1'b1);
        wait_oe("t5_oe_restart");
        chk("t5_restart_addr", 32'(bus.vramAddr), 32'h0);

        // 6: reset in the middle of a write strobe
        wait_ph(2);
        push(15'h300, 8'h5A);
        push(15'h301, 8'h6B);
        found = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.nVramWE == 1'b0) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("t6_we_seen", 32'(found), 32'd1);
        chk("t6_we_phase", 32'(m_ph), 32'd5);
        nReset = 1'b0;
        #1;
        chk("t6_we_abort", 32'(bus.nVramWE), 32'd1);
        chk("t6_doe_abort", 32'(bus.vramDoe), 32'd0);
        chk("t6_oe_idle", 32'(bus.nVramOE), 32'd1);
        repeat (3) tick();
        nReset = 1'b1;
        chk("t6_full_clear", 32'(bus.wrFull), 32'd0);
        chk("t6_ovf_clear", 32'(bus.wrOvf), 32'd0);
        we_ph_q.delete();
        we_cyc_q.delete();
        oe_low_cnt = 0;
        repeat (40) tick();
        chk("t6_no_writes", 32'(we_ph_q.size()), 32'd0);
        chk("t6_no_fetch", 32'(oe_low_cnt), 32'd0);

        // final report
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
